btn_evt_tx: RTL and testbench
=============================

Name: btn_evt_tx

Overview:
- Sits directly downstream of the button debouncer, upstream of the UART byte transmitter.
- Takes the debounced button vector and detects press edges per button.
- Queues one pending event per button and serialises each event as a 4-byte ASCII message: 'K', hex index, CR, LF.
- Drives the transmitter through a valid/ready byte handshake, so button presses become visible on the serial terminal.

Parameters:
- BT_WIDTH, 8: number of buttons; legal range 1..16.
- PRESS_LVL, 1'b1: btn_in level that means "pressed". A press edge is a transition to this level.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- btn_in  input  BT_WIDTH  debounced button levels, already synchronous to clk.
- tx_ready  input  1  transmitter can accept tx_data this cycle.
- tx_data  output  8  current message byte.
- tx_valid  output  1  tx_data valid; byte transferred on an edge where tx_valid & tx_ready.
- busy  output  1  message in progress (state != IDLE).
- evt_drop  output  BT_WIDTH  one-cycle pulse per button whose press was lost.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, pending=0, tx_valid=0, tx_data=8'h00, busy=0, evt_drop=0, armed=0.
  - Takes effect on the same edge even mid-message. The partial message is abandoned and never resumed.
- Arming: the first edge with rst_n=1 loads prev=btn_in and sets armed=1; no edges are detected on that edge. A button held through reset produces no event.
- Press detect (when armed):
  - press[i] = (btn_in[i]==PRESS_LVL) && (prev[i]!=PRESS_LVL).
  - prev <= btn_in every edge.
  - Releases are ignored.
- Pending register, BT_WIDTH bits:
  - A press sets pending[i] on the same edge.
  - If pending[i] is already 1, evt_drop[i] pulses for exactly one cycle (registered) and pending stays 1.
  - If a set and a clear of the same bit occur on one edge, the set wins and there is no drop.
- FSM states: IDLE, SEND.
  - IDLE: if pending != 0, select sel = lowest set index.
    - Clear pending[sel], load byte_idx=0, tx_data='K' (8'h4B), tx_valid=1, go to SEND.
  - SEND: hold tx_data and tx_valid stable until tx_valid & tx_ready.
    - On transfer, byte_idx increments and tx_data loads the next byte on the same edge, giving zero-bubble back-to-back bytes when tx_ready stays high.
    - Byte sequence: 'K', hex(sel), 8'h0D, 8'h0A.
    - hex(sel): 0-9 maps to 8'h30+sel; 10-15 maps to 8'h41+sel-10.
    - On transfer of byte 3: tx_valid=0, go to IDLE.
  - After a message ends, the next message starts on the following edge, so exactly one idle cycle separates messages.
- Latency: btn_in reaches the press level before edge E0 → pending set at E0 → tx_valid=1 with 'K' after E1 (IDLE, no message in flight).
- tx_valid never drops without a transfer, except on reset.
- A press of the button currently being sent re-queues it; a new message follows.
- Throughput: with tx_ready tied high, a message takes 4 cycles plus 1 idle cycle.

Test Plan:
- Reset with btn_in=8'h01 held, then release rst_n → no tx_valid for 20 cycles; pending=0; no evt_drop.
- btn_in 8'h00→8'h04, tx_ready=1 → tx_valid 1 cycle after pending sets; bytes 4B,32,0D,0A on 4 consecutive edges; busy deasserts after byte 3.
- btn_in 8'h00→8'h81 on one edge, tx_ready=1 → message for "K0\r\n", one idle cycle, then "K7\r\n".
- tx_ready toggled 1/0 per cycle during message for index 11 → tx_data/tx_valid stable while tx_ready=0; bytes 4B,42,0D,0A each transferred exactly once.
- tx_ready=0, press button 3, release, press again → first press sets pending; second press gives evt_drop=8'h08 for exactly one cycle; exactly one "K3" message after tx_ready=1.
- rst_n=0 pulsed after byte 'K' transfers in a message → tx_valid=0 on the reset edge; no remaining bytes are sent; the next press yields a fresh full 4-byte message.

Source files
------------

// File: rtl/btn_evt_tx_if.sv
// Byte handshake between the button event serialiser and the UART
// transmitter. A byte moves on a rising clock edge where tx_valid and
// tx_ready are both high.
interface btn_evt_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // The serialiser drives data and valid.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // The transmitter accepts bytes.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/btn_evt_tx.sv
// Button press to ASCII event serialiser.
// Detects press edges on a debounced button vector and keeps one pending
// event per button. Each event goes out as the four bytes 'K', hex index,
// CR, LF on a valid/ready byte stream, lowest button index first.
module btn_evt_tx #(
    parameter int   BT_WIDTH  = 8,
    parameter logic PRESS_LVL = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BT_WIDTH-1:0] btn_in,
    btn_evt_tx_if.master        tx,
    output logic                busy,
    output logic [BT_WIDTH-1:0] evt_drop
);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Button index to one upper-case hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_armed;
    logic [BT_WIDTH-1:0] r_prev;
    logic [BT_WIDTH-1:0] r_pending;
    logic [BT_WIDTH-1:0] r_evt_drop;
    logic [3:0]          r_sel;
    logic [3:0]          w_sel_nxt;
    logic [1:0]          r_byte_idx;
    logic [1:0]          w_byte_idx_nxt;
    logic [7:0]          r_tx_data;
    logic [7:0]          w_tx_data_nxt;
    logic                r_tx_valid;
    logic                w_tx_valid_nxt;
    logic                w_take;
    logic [3:0]          w_low_idx;
    logic [BT_WIDTH-1:0] w_lvl_now;
    logic [BT_WIDTH-1:0] w_lvl_prev;
    logic [BT_WIDTH-1:0] w_press;
    logic [BT_WIDTH-1:0] w_clr;
    logic [BT_WIDTH-1:0] w_drop;
    logic [BT_WIDTH-1:0] w_pending_nxt;

    // A bit is 1 where the button sits at the pressed level.
    assign w_lvl_now  = btn_in ~^ {BT_WIDTH{PRESS_LVL}};
    assign w_lvl_prev = r_prev ~^ {BT_WIDTH{PRESS_LVL}};

    // Press edges only count once armed, so a button held through reset is ignored.
    assign w_press = w_lvl_now & ~w_lvl_prev & {BT_WIDTH{r_armed}};

    // Starting a message retires the pending bit it was chosen from.
    assign w_clr = w_take ? (BT_WIDTH'(1) << w_low_idx) : '0;

    // A press on an already pending bit is lost unless that bit is retired on
    // the same edge; in that case the press simply re-queues the button.
    assign w_drop        = w_press & r_pending & ~w_clr;
    assign w_pending_nxt = (r_pending & ~w_clr) | w_press;

    // Lowest pending index; scanning downward lets the lowest set bit win.
    always_comb begin
        w_low_idx = '0;
        for (int i = BT_WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = 4'(i);
            end
        end
    end

    // Next state and next message byte.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would infer a latch.
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_byte_idx_nxt = r_byte_idx;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_take         = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (|r_pending) begin
                    w_take         = 1'b1;
                    w_sel_nxt      = w_low_idx;
                    w_byte_idx_nxt = 2'd0;
                    w_tx_data_nxt  = ASCII_K;
                    w_tx_valid_nxt = 1'b1;
                    w_state_nxt    = S_SEND;
                end
            end
            S_SEND: begin
                // Data and valid only move on a transfer, so they hold while stalled.
                if (r_tx_valid && tx.tx_ready) begin
                    unique case (r_byte_idx)
                        2'd0: begin
                            w_tx_data_nxt  = hex_ascii(r_sel);
                            w_byte_idx_nxt = 2'd1;
                        end
                        2'd1: begin
                            w_tx_data_nxt  = ASCII_CR;
                            w_byte_idx_nxt = 2'd2;
                        end
                        2'd2: begin
                            w_tx_data_nxt  = ASCII_LF;
                            w_byte_idx_nxt = 2'd3;
                        end
                        2'd3: begin
                            w_tx_valid_nxt = 1'b0;
                            w_state_nxt    = S_IDLE;
                        end
                    endcase
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state and transmit registers; reset abandons any message in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_byte_idx <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
        end
    end

    // Arming, previous levels, pending events and registered drop pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_armed    <= 1'b0;
            r_prev     <= '0;
            r_pending  <= '0;
            r_evt_drop <= '0;
        end else begin
            r_armed    <= 1'b1;
            r_prev     <= btn_in;
            r_pending  <= w_pending_nxt;
            r_evt_drop <= w_drop;
        end
    end

    assign tx.tx_data  = r_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign busy        = (r_state == S_SEND);
    assign evt_drop    = r_evt_drop;

endmodule

// File: tb/tb_btn_evt_tx.sv
// Bench for btn_evt_tx. Directed stimulus pushes the hand-written byte
// stream it expects into a queue; a monitor pops and compares each byte the
// DUT hands over, and also checks that stalled bytes hold steady.
module tb_btn_evt_tx;

    localparam int BT_WIDTH = 16;

    logic                clk;
    logic                rst_n;
    logic [BT_WIDTH-1:0] btn_in;
    logic                busy;
    logic [BT_WIDTH-1:0] evt_drop;

    btn_evt_tx_if u_if ();

    btn_evt_tx #(
        .BT_WIDTH  (BT_WIDTH),
        .PRESS_LVL (1'b1)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .tx       (u_if.master),
        .busy     (busy),
        .evt_drop (evt_drop)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_msg(input logic [7:0] digit);
        exp_q.push_back(8'h4B);
        exp_q.push_back(digit);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Wait, bounded, until every expected byte has been seen and the DUT is idle.
    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || u_if.tx_valid) && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: samples on the falling edge what the next rising edge will do.
    initial begin
        logic       prv_hold = 1'b0;
        logic [7:0] prv_data = 8'h00;
        forever begin
            @(negedge clk);
            if (prv_hold) begin
                check("hold_valid", {31'h0, u_if.tx_valid}, 32'd1);
                check("hold_data", {24'h0, u_if.tx_data}, {24'h0, prv_data});
            end
            if (rst_n && u_if.tx_valid && u_if.tx_ready) begin
                if (exp_q.size() == 0) begin
                    // No byte was expected; 9'h100 can never match an 8-bit value.
                    check("unexpected_byte", {24'h0, u_if.tx_data}, 32'h100);
                end else begin
                    check("byte", {24'h0, u_if.tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
            prv_hold = rst_n && u_if.tx_valid && !u_if.tx_ready;
            prv_data = u_if.tx_data;
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int bad;

        // Reset with button 0 held; it must not produce an event.
        rst_n         = 1'b0;
        btn_in        = 16'h0001;
        u_if.tx_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", {31'h0, u_if.tx_valid}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_data", {24'h0, u_if.tx_data}, 32'h00);
        check("rst_drop", {16'h0, evt_drop}, 32'h0);
        rst_n = 1'b1;
        bad   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (u_if.tx_valid || busy || (evt_drop != '0)) bad++;
        end
        check("held_through_reset", 32'(bad), 32'd0);
        btn_in = 16'h0000;
        repeat (2) tick();

        // Single press of button 2: latency, back-to-back bytes, busy.
        push_msg(8'h32);
        btn_in = 16'h0004;
        tick();                                   // E0: pending set
        check("lat_e0_valid", {31'h0, u_if.tx_valid}, 32'd0);
        tick();                                   // E1: 'K' presented
        check("lat_e1_valid", {31'h0, u_if.tx_valid}, 32'd1);
        check("lat_e1_data", {24'h0, u_if.tx_data}, 32'h4B);
        check("lat_e1_busy", {31'h0, busy}, 32'd1);
        repeat (3) tick();                        // E2..E4
        check("b2b_last_data", {24'h0, u_if.tx_data}, 32'h0A);
        check("b2b_busy", {31'h0, busy}, 32'd1);
        tick();                                   // E5: byte 3 transferred
        check("end_busy", {31'h0, busy}, 32'd0);
        check("end_valid", {31'h0, u_if.tx_valid}, 32'd0);
        btn_in = 16'h0000;
        drain("drain_single");
        repeat (3) tick();

        // Buttons 0 and 7 together: lowest first, one idle cycle between.
        push_msg(8'h30);
        push_msg(8'h37);
        btn_in = 16'h0081;
        tick();                                   // E0
        tick();                                   // E1: K0 starts
        repeat (4) tick();                        // E2..E5
        check("gap_valid", {31'h0, u_if.tx_valid}, 32'd0);
        check("gap_busy", {31'h0, busy}, 32'd0);
        tick();                                   // E6: K7 starts
        check("second_valid", {31'h0, u_if.tx_valid}, 32'd1);
        check("second_data", {24'h0, u_if.tx_data}, 32'h4B);
        btn_in = 16'h0000;
        drain("drain_pair");
        repeat (3) tick();

        // Button 11 with tx_ready toggling every cycle.
        push_msg(8'h42);
        btn_in = 16'h0800;
        for (int i = 0; i < 16; i++) begin
            tick();
            u_if.tx_ready = ~u_if.tx_ready;
        end
        u_if.tx_ready = 1'b1;
        btn_in        = 16'h0000;
        drain("drain_toggle");
        repeat (3) tick();

        // Button 5 stalls in SEND; button 3 pressed twice while pending.
        push_msg(8'h35);
        push_msg(8'h33);
        u_if.tx_ready = 1'b0;
        btn_in        = 16'h0020;
        tick();                                   // pending[5]
        tick();                                   // K5 presented, stalled
        btn_in = 16'h0028;
        tick();                                   // pending[3] set
        check("first_press_drop", {16'h0, evt_drop}, 32'h0);
        btn_in = 16'h0020;
        tick();                                   // release
        btn_in = 16'h0028;
        tick();                                   // second press is lost
        check("drop_pulse", {16'h0, evt_drop}, 32'h0008);
        tick();
        check("drop_one_cycle", {16'h0, evt_drop}, 32'h0);
        btn_in        = 16'h0000;
        u_if.tx_ready = 1'b1;
        drain("drain_drop");
        repeat (3) tick();

        // Reset right after 'K' of button 1 transfers.
        exp_q.push_back(8'h4B);
        btn_in = 16'h0002;
        tick();                                   // E0
        tick();                                   // E1: 'K'
        tick();                                   // E2: 'K' transferred
        check("pre_rst_data", {24'h0, u_if.tx_data}, 32'h31);
        rst_n = 1'b0;
        tick();                                   // reset edge
        check("midrst_valid", {31'h0, u_if.tx_valid}, 32'd0);
        check("midrst_busy", {31'h0, busy}, 32'd0);
        rst_n  = 1'b1;
        btn_in = 16'h0000;
        repeat (10) tick();
        check("abandon_q", 32'(exp_q.size()), 32'd0);
        check("abandon_idle", {31'h0, u_if.tx_valid}, 32'd0);
        push_msg(8'h31);
        btn_in = 16'h0002;
        tick();
        btn_in = 16'h0000;
        drain("drain_after_rst");
        repeat (10) tick();
        check("final_q", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
